// File: rtl/ps2_pkg.sv
// Shared constants, frame state type and the default key map for the PS/2 key decoder.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_BRK    = 8'hF0;
  localparam logic [7:0] PS2_IGN_E1 = 8'hE1;
  localparam logic [7:0] PS2_IGN_AA = 8'hAA;
  localparam logic [7:0] PS2_IGN_FA = 8'hFA;
  localparam logic [7:0] PS2_IGN_EE = 8'hEE;
  localparam logic [7:0] PS2_IGN_FE = 8'hFE;

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StParity,
    StStop
  } frame_state_e;

  localparam int unsigned PS2_DEFAULT_NUM_KEYS = 17;

  // Entry i lives at [9i+8:9i] as {ext, code}; listed here from entry 16 down to entry 0.
  localparam logic [PS2_DEFAULT_NUM_KEYS*9-1:0] PS2_DEFAULT_KEY_CODES = {
    9'h174, 9'h16B, 9'h172, 9'h175,  // right, left, down, up arrows
    9'h006, 9'h005, 9'h076, 9'h05A,  // F2, F1, Esc, Enter
    9'h04B, 9'h03B, 9'h042, 9'h043,  // L, J, K, I
    9'h029, 9'h023, 9'h01C, 9'h01B,  // Space, D, A, S
    9'h01D                           // W
  };

  function automatic logic is_ignore_code(input logic [7:0] b);
    return (b == PS2_IGN_E1) || (b == PS2_IGN_AA) || (b == PS2_IGN_FA) ||
           (b == PS2_IGN_EE) || (b == PS2_IGN_FE);
  endfunction

endpackage

// File: rtl/ps2_input_filter.sv
// Synchronises and debounces the raw PS/2 clock and data lines, and flags filtered clock falls.
module ps2_input_filter #(
  parameter int unsigned DEBOUNCE_CYCLES = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic kclk,
  input  logic kdata,
  output logic kdata_filt,
  output logic fall_evt
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  // Bit 0 carries kclk, bit 1 carries kdata.
  logic [1:0]      sync1_q, sync2_q, filt_q, filt_d;
  logic [CntW-1:0] cnt_q [2];
  logic [CntW-1:0] cnt_d [2];
  logic            fall_q, fall_d;

  always_comb begin
    filt_d = filt_q;
    for (int i = 0; i < 2; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != filt_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          filt_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
    fall_d = filt_q[0] & ~filt_d[0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 2'b11;
      sync2_q <= 2'b11;
      filt_q  <= 2'b11;
      fall_q  <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q <= {kdata, kclk};
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
      fall_q  <= fall_d;
      for (int i = 0; i < 2; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // fall_q is aligned with the cycle in which the filtered clock first reads 0.
  assign fall_evt   = fall_q;
  assign kdata_filt = filt_q[1];

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 frame receiver with E0/F0 prefix handling and a configurable scan-code to key-state map.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned           NUM_KEYS        = PS2_DEFAULT_NUM_KEYS,
  parameter logic [NUM_KEYS*9-1:0] KEY_CODES       = PS2_DEFAULT_KEY_CODES,
  parameter int unsigned           DEBOUNCE_CYCLES = 20,
  parameter int unsigned           TIMEOUT_CYCLES  = 50000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                kclk,
  input  logic                kdata,
  output logic [NUM_KEYS-1:0] key_down,
  output logic [NUM_KEYS-1:0] key_press,
  output logic                scan_valid,
  output logic [7:0]          scan_code,
  output logic                scan_ext,
  output logic                scan_break,
  output logic                frame_err
);

  localparam int unsigned IdleW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IdleW-1:0] IdleMax = IdleW'(TIMEOUT_CYCLES);

  logic fall_evt, data;

  ps2_input_filter #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_filter (
    .clk       (clk),
    .rst       (rst),
    .kclk      (kclk),
    .kdata     (kdata),
    .kdata_filt(data),
    .fall_evt  (fall_evt)
  );

  frame_state_e   state_q, state_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     shift_q, shift_d;
  logic           par_ok_q, par_ok_d;
  logic [IdleW-1:0] idle_cnt_q, idle_cnt_d;
  logic           byte_acc, frame_err_d;
  logic           ext_q, ext_d, brk_q, brk_d;
  logic [NUM_KEYS-1:0] key_down_d, key_press_d;
  logic           scan_valid_d, scan_ext_d, scan_break_d;
  logic [7:0]     scan_code_d;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    par_ok_d    = par_ok_q;
    idle_cnt_d  = idle_cnt_q;
    byte_acc    = 1'b0;
    frame_err_d = 1'b0;
    if (fall_evt) begin
      idle_cnt_d = '0;
      unique case (state_q)
        StIdle: begin
          if (!data) begin
            state_d   = StData;
            bit_cnt_d = '0;
          end
        end
        StData: begin
          shift_d   = {data, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = StParity;
        end
        StParity: begin
          par_ok_d = ^{shift_q, data};
          state_d  = StStop;
        end
        StStop: begin
          if (data && par_ok_q) byte_acc = 1'b1;
          else frame_err_d = 1'b1;
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end else if (state_q != StIdle) begin
      if (idle_cnt_q == IdleMax) begin
        state_d     = StIdle;
        idle_cnt_d  = '0;
        frame_err_d = 1'b1;
      end else begin
        idle_cnt_d = idle_cnt_q + 1'b1;
      end
    end else begin
      idle_cnt_d = '0;
    end
  end

  always_comb begin
    ext_d        = ext_q;
    brk_d        = brk_q;
    scan_valid_d = 1'b0;
    scan_code_d  = scan_code;
    scan_ext_d   = scan_ext;
    scan_break_d = scan_break;
    key_down_d   = key_down;
    key_press_d  = '0;
    if (frame_err_d) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (byte_acc) begin
      if (shift_q == PS2_EXT) begin
        ext_d = 1'b1;
      end else if (shift_q == PS2_BRK) begin
        brk_d = 1'b1;
      end else if (is_ignore_code(shift_q)) begin
        ext_d = 1'b0;
        brk_d = 1'b0;
      end else begin
        scan_valid_d = 1'b1;
        scan_code_d  = shift_q;
        scan_ext_d   = ext_q;
        scan_break_d = brk_q;
        ext_d        = 1'b0;
        brk_d        = 1'b0;
        for (int i = 0; i < int'(NUM_KEYS); i++) begin
          if (KEY_CODES[9*i +: 9] == {ext_q, shift_q}) begin
            if (brk_q) begin
              key_down_d[i] = 1'b0;
            end else begin
              key_down_d[i]  = 1'b1;
              key_press_d[i] = ~key_down[i];
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_ok_q   <= 1'b0;
      idle_cnt_q <= '0;
      ext_q      <= 1'b0;
      brk_q      <= 1'b0;
      key_down   <= '0;
      key_press  <= '0;
      scan_valid <= 1'b0;
      scan_code  <= '0;
      scan_ext   <= 1'b0;
      scan_break <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_ok_q   <= par_ok_d;
      idle_cnt_q <= idle_cnt_d;
      ext_q      <= ext_d;
      brk_q      <= brk_d;
      key_down   <= key_down_d;
      key_press  <= key_press_d;
      scan_valid <= scan_valid_d;
      scan_code  <= scan_code_d;
      scan_ext   <= scan_ext_d;
      scan_break <= scan_break_d;
      frame_err  <= frame_err_d;
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: drives PS/2 frames bit by bit and checks decoded key state.
module tb_ps2_key_decoder;

  localparam int unsigned NK = 17;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          kclk = 1'b1;
  logic          kdata = 1'b1;
  logic [NK-1:0] key_down, key_press;
  logic          scan_valid, scan_ext, scan_break, frame_err;
  logic [7:0]    scan_code;

  int n_vec = 0;
  int n_err = 0;
  int sv_cnt = 0, fe_cnt = 0, kp_cnt = 0;
  int sv0, fe0, kp0;
  logic [NK-1:0] kp_last = '0;

  always #5 clk = ~clk;

  ps2_key_decoder #(
    .NUM_KEYS       (NK),
    .DEBOUNCE_CYCLES(4),
    .TIMEOUT_CYCLES (200)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .kclk      (kclk),
    .kdata     (kdata),
    .key_down  (key_down),
    .key_press (key_press),
    .scan_valid(scan_valid),
    .scan_code (scan_code),
    .scan_ext  (scan_ext),
    .scan_break(scan_break),
    .frame_err (frame_err)
  );

  // Pulse counters sampled away from the active edge.
  always @(negedge clk) begin
    if (scan_valid) sv_cnt++;
    if (frame_err) fe_cnt++;
    if (key_press != '0) begin
      kp_cnt += $countones(key_press);
      kp_last = key_press;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] frame(input logic [7:0] b, input logic par_bad,
                                        input logic stop);
    return {stop, (~^b) ^ par_bad, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      kdata = bits[i];
      repeat (10) @(negedge clk);
      kclk = 1'b0;
      repeat (20) @(negedge clk);
      kclk = 1'b1;
      repeat (10) @(negedge clk);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(frame(b, 1'b0, 1'b1), 11);
    repeat (5) @(negedge clk);
  endtask

  task automatic snap();
    sv0 = sv_cnt;
    fe0 = fe_cnt;
    kp0 = kp_cnt;
  endtask

  initial begin
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_key_down", 32'(key_down), 32'h0);
    check("rst_key_press", 32'(key_press), 32'h0);
    check("rst_scan", {22'h0, scan_valid, scan_ext, scan_break, frame_err, scan_code}, 32'h0);

    // First make of W, then typematic repeat.
    snap();
    send_byte(8'h1D);
    check("w_down", 32'(key_down), 32'h1);
    check("w_press_cnt", 32'(kp_cnt - kp0), 32'd1);
    check("w_press_vec", 32'(kp_last), 32'h1);
    check("w_sv_cnt", 32'(sv_cnt - sv0), 32'd1);
    check("w_scan", {23'h0, scan_ext, scan_code}, 32'h01D);
    check("w_brk", 32'(scan_break), 32'h0);
    snap();
    send_byte(8'h1D);
    check("w_rep_press", 32'(kp_cnt - kp0), 32'd0);
    check("w_rep_down", 32'(key_down), 32'h1);
    check("w_rep_sv", 32'(sv_cnt - sv0), 32'd1);

    // Break of W.
    snap();
    send_byte(8'hF0);
    send_byte(8'h1D);
    check("w_brk_down", 32'(key_down), 32'h0);
    check("w_brk_flag", 32'(scan_break), 32'h1);
    check("w_brk_press", 32'(kp_cnt - kp0), 32'd0);
    check("w_brk_sv", 32'(sv_cnt - sv0), 32'd1);

    // Extended up arrow vs keypad 8.
    snap();
    send_byte(8'hE0);
    send_byte(8'h75);
    check("up_down", 32'(key_down), 32'h2000);
    check("up_scan", {22'h0, scan_break, scan_ext, scan_code}, 32'h175);
    check("up_sv", 32'(sv_cnt - sv0), 32'd1);
    snap();
    send_byte(8'h75);
    check("kp8_down", 32'(key_down), 32'h2000);
    check("kp8_scan", {22'h0, scan_break, scan_ext, scan_code}, 32'h075);
    check("kp8_sv", 32'(sv_cnt - sv0), 32'd1);
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h75);
    check("up_brk_down", 32'(key_down), 32'h0);
    check("up_brk_scan", {22'h0, scan_break, scan_ext, scan_code}, 32'h375);

    // Parity and stop errors.
    snap();
    send_bits(frame(8'h29, 1'b1, 1'b1), 11);
    repeat (5) @(negedge clk);
    check("par_fe", 32'(fe_cnt - fe0), 32'd1);
    check("par_sv", 32'(sv_cnt - sv0), 32'd0);
    check("par_down", 32'(key_down), 32'h0);
    snap();
    send_bits(frame(8'h1C, 1'b0, 1'b0), 11);
    kdata = 1'b1;
    repeat (5) @(negedge clk);
    check("stop_fe", 32'(fe_cnt - fe0), 32'd1);
    check("stop_sv", 32'(sv_cnt - sv0), 32'd0);

    // Timeout on a partial frame also drops a pending E0.
    send_byte(8'hE0);
    snap();
    send_bits(frame(8'h5A, 1'b0, 1'b1), 5);
    repeat (300) @(negedge clk);
    check("to_fe", 32'(fe_cnt - fe0), 32'd1);
    check("to_sv", 32'(sv_cnt - sv0), 32'd0);
    kdata = 1'b1;
    send_byte(8'h75);
    check("to_ext_clr", {23'h0, scan_ext, scan_code}, 32'h075);
    check("to_down", 32'(key_down), 32'h0);
    snap();
    send_byte(8'h5A);
    check("enter_down", 32'(key_down), 32'h200);
    check("enter_press", 32'(kp_cnt - kp0), 32'd1);

    // Reset in the middle of a frame.
    snap();
    send_bits(frame(8'h23, 1'b0, 1'b1), 7);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    kdata = 1'b1;
    repeat (300) @(negedge clk);
    check("mid_rst_down", 32'(key_down), 32'h0);
    check("mid_rst_scan", {22'h0, scan_valid, scan_ext, scan_break, frame_err, scan_code},
          32'h0);
    check("mid_rst_fe", 32'(fe_cnt - fe0), 32'd0);
    check("mid_rst_sv", 32'(sv_cnt - sv0), 32'd0);

    // Short kclk glitches with data low must not start a frame.
    snap();
    kdata = 1'b0;
    for (int g = 1; g <= 3; g++) begin
      kclk = 1'b0;
      repeat (g) @(negedge clk);
      kclk = 1'b1;
      repeat (10) @(negedge clk);
    end
    repeat (300) @(negedge clk);
    check("glitch_fe", 32'(fe_cnt - fe0), 32'd0);
    check("glitch_sv", 32'(sv_cnt - sv0), 32'd0);
    kdata = 1'b1;
    repeat (10) @(negedge clk);
    snap();
    send_byte(8'h1D);
    check("post_glitch_down", 32'(key_down), 32'h1);
    check("post_glitch_press", 32'(kp_cnt - kp0), 32'd1);
    check("post_glitch_fe", 32'(fe_cnt - fe0), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
